cv32e40x_pma_gate: RTL

CV32E40X_PMA_GATE -- requirements
Module: cv32e40x_pma_gate

---
 rtl/cv32e40x_pma_gate.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cv32e40x_pma_gate.sv
// cv32e40x_pma_gate
//
// Sits between the core request port and the bus and applies the PMA checker
// verdict. Legal requests are forwarded combinationally while fewer than
// MAX_OUTSTANDING transactions await a response. A rejected request
// (pma_err_i or pma_block_i) is consumed and never forwarded. The gate then
// waits for every outstanding bus response to drain and returns a single
// error response that is tagged as a PMA error. This keeps responses in
// request order.
//
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both 1. Valid does not wait for ready. Responses have no ready
// signal: a response is taken in the cycle its valid is 1.
//
// Parameters:
//   MAX_OUTSTANDING  bus transactions awaiting a response (1..7)
//   IF_STAGE         1 = instruction fetch instance, 0 = load/store
//
// Optional feature (macro CV32E40X_PMA_GATE_ERR_ADDR_EN):
//   defined   err_addr_o is a register holding the address of the last
//             rejected request
//   undefined err_addr_o is tied to 0 and no capture register exists
//
// Ports:
//   clk                      clock, rising edge
//   rst_n                    asynchronous reset, active HIGH despite its name
//   core_trans_*             core request (valid/ready, addr, we)
//   pma_*_i                  PMA verdict for core_trans_addr_i, same cycle
//   bus_trans_*              bus request (valid/ready, addr, we, attributes)
//   bus_resp_valid_i/err_i   bus response
//   core_resp_*              response to the core (pma_err marks gate errors)
//   err_addr_o               last rejected address (see macro above)
//   err_is_fetch_o           constant IF_STAGE tag
//   dbg_state_o              FSM state: 0 IDLE, 1 DRAIN, 2 ERR_RESP
module cv32e40x_pma_gate #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int IF_STAGE        = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_trans_valid_i,
  output logic        core_trans_ready_o,
  input  logic [31:0] core_trans_addr_i,
  input  logic        core_trans_we_i,
  input  logic        pma_err_i,
  input  logic        pma_block_i,
  input  logic        pma_bufferable_i,
  input  logic        pma_cacheable_i,
  output logic        bus_trans_valid_o,
  input  logic        bus_trans_ready_i,
  output logic [31:0] bus_trans_addr_o,
  output logic        bus_trans_we_o,
  output logic        bus_trans_bufferable_o,
  output logic        bus_trans_cacheable_o,
  input  logic        bus_resp_valid_i,
  input  logic        bus_resp_err_i,
  output logic        core_resp_valid_o,
  output logic        core_resp_err_o,
  output logic        core_resp_pma_err_o,
  output logic [31:0] err_addr_o,
  output logic        err_is_fetch_o,
  output logic [1:0]  dbg_state_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    ERR_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             reject;
  logic             room;
  logic             accept;
  logic             retire;

  assign reject = core_trans_valid_i & (pma_err_i | pma_block_i);
  assign room   = (cnt_q < MAX_CNT);

  // Address and attributes go straight through. Only valid is gated.
  assign bus_trans_addr_o       = core_trans_addr_i;
  assign bus_trans_we_o         = core_trans_we_i;
  assign bus_trans_bufferable_o = pma_bufferable_i;
  assign bus_trans_cacheable_o  = pma_cacheable_i;

  always_comb begin
    bus_trans_valid_o   = 1'b0;
    core_trans_ready_o  = 1'b0;
    core_resp_valid_o   = bus_resp_valid_i;
    core_resp_err_o     = bus_resp_err_i;
    core_resp_pma_err_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (reject) begin
          // Consume the rejected request. Its error response comes later.
          core_trans_ready_o = 1'b1;
        end else begin
          bus_trans_valid_o  = core_trans_valid_i & room;
          core_trans_ready_o = bus_trans_ready_i & room;
        end
      end
      ERR_RESP: begin
        core_resp_valid_o   = 1'b1;
        core_resp_err_o     = 1'b1;
        core_resp_pma_err_o = 1'b1;
      end
      default: ;
    endcase
    // Hold every output quiet while reset is asserted, not only after an edge.
    if (rst_n) begin
      bus_trans_valid_o   = 1'b0;
      core_trans_ready_o  = 1'b0;
      core_resp_valid_o   = 1'b0;
      core_resp_err_o     = 1'b0;
      core_resp_pma_err_o = 1'b0;
    end
  end

  assign accept = bus_trans_valid_o & bus_trans_ready_i;
  // A stray response with nothing outstanding must not wrap the counter.
  assign retire = bus_resp_valid_i & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // The drain decision uses cnt_d, so a response that arrives in the same
  // cycle is already counted.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        IDLE:     if (reject) state_q <= (cnt_d == '0) ? ERR_RESP : DRAIN;
        DRAIN:    if (cnt_d == '0) state_q <= ERR_RESP;
        ERR_RESP: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

`ifdef CV32E40X_PMA_GATE_ERR_ADDR_EN
  logic [31:0] err_addr_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      err_addr_q <= '0;
    end else if ((state_q == IDLE) && reject) begin
      err_addr_q <= core_trans_addr_i;
    end
  end

  assign err_addr_o = err_addr_q;
`else
  assign err_addr_o = '0;
`endif

  assign err_is_fetch_o = (IF_STAGE != 0);
  assign dbg_state_o    = state_q;

`ifndef SYNTHESIS
  resp_without_outstanding: assert property (
    @(posedge clk) disable iff (rst_n) !(bus_resp_valid_i && (cnt_q == '0))
  );
`endif

endmodule
